temperature_sample_scheduler: RTL and testbench
===============================================

# temperature_sample_scheduler

- Sequences temperature acquisition for the on-board sensor path.
- Waits out the sensor's power-up/first-frame window, then snapshots the 8-bit decoded temperature byte from the I2C sensor interface at a fixed sample period.
- Optionally smooths samples with a 4-sample moving average.
- Publishes each result to a downstream consumer over a valid/ready handshake and maintains a hysteretic over-temperature alarm.

## Interface
- `WARMUP`, 2560: cycles after enable before sampling starts; covers the sensor interface's first complete frame.
- `SAMPLE_PERIOD`, 2800: cycles between sample ticks; minimum 4.
- `HIGH_THRESH`, 8'd30: `over_temp` sets when `temp_out >= HIGH_THRESH`.
- `LOW_THRESH`, 8'd28: `over_temp` clears when `temp_out <= LOW_THRESH`; must be `< HIGH_THRESH`.
- `clk_200KHz` input 1: single system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run request; low forces IDLE.
- `temperature_in` input 8: decoded temperature from the sensor interface, unsigned °C.
- `temp_ready` input 1: consumer accepts `temp_out` when high together with `temp_valid`.
- `temp_out` output 8: published temperature.
- `temp_valid` output 1: `temp_out` holds an unconsumed sample.
- `over_temp` output 1: hysteretic alarm, tracks `temp_out`.
- `overrun` output 1: one-cycle pulse when a publish is dropped.

## Operation
- **Reset values:** all outputs 0; state IDLE; counters 0; averaging window empty.
- **IDLE:** counters held at 0. `enable=1` moves to WARMUP on the next edge.
- **WARMUP:** `warm_cnt` counts 0..WARMUP-1. At terminal count, move to RUN with `period_cnt=0`.
- **RUN:** `period_cnt` counts 0..SAMPLE_PERIOD-1 and wraps. The edge at terminal count is the capture edge.
  - At the capture edge, `temperature_in` is written into the window.
  - If the window is empty, all 4 entries are preloaded with the sample; otherwise the oldest entry is replaced.
- **Average:** 10-bit sum of the 4 entries, result = `sum[9:2]` (truncate, no rounding).
- **Publish edge:** the edge after the capture edge.
  - If `temp_valid=0`, or `temp_ready=1` at that edge: load `temp_out` with the new result, set `temp_valid=1`, update `over_temp`.
  - Otherwise (`temp_valid=1`, `temp_ready=0`): `temp_out` and `over_temp` hold, `overrun` pulses for one cycle, and the sample is dropped. The window is still updated.
- **Handshake:**
  - A transfer occurs on any edge with `temp_valid & temp_ready`.
  - After a transfer, `temp_valid` falls unless the same edge is a publish edge, in which case it stays high with the new data.
  - `temp_out` is stable while `temp_valid=1`.
- **Alarm:** set when `temp_out >= HIGH_THRESH`, clear when `temp_out <= LOW_THRESH`, otherwise hold. Evaluated only on a successful publish.
- **`enable` falling in WARMUP or RUN:**
  - Next edge moves to IDLE, clears counters and `temp_valid`, and marks the window empty.
  - `temp_out` and `over_temp` hold.
  - A pending capture or publish on that same edge is discarded.
- **`rst_n` low at any time:** immediate return to reset values with no clock required. The next run restarts from WARMUP with the window empty.

## Timing
- Enable to first capture edge: WARMUP + SAMPLE_PERIOD cycles. Capture to `temp_valid`: 1 cycle.
- Steady-state publish rate: one per SAMPLE_PERIOD cycles.
- `overrun` is registered and high for exactly one cycle per dropped sample.
- No combinational path from inputs to outputs.

## Configuration
- **`TEMP_AVG_EN` defined:** 4-entry window and averaging as described above.
- **`TEMP_AVG_EN` undefined:**
  - The window and sum are not built.
  - The publish edge loads the sample latched at the capture edge directly.
  - Handshake, alarm, overrun and timing are identical.

## Test plan
- **Reset/first sample:** assert `rst_n` low mid-run → all outputs 0 asynchronously. Release, `enable=1`, `temperature_in=25`, `temp_ready=1` → first `temp_valid` pulse with `temp_out=25` exactly WARMUP+SAMPLE_PERIOD+1 cycles after enable.
- **Averaging (`TEMP_AVG_EN`):** samples 20, 24, 28, 32 on successive ticks, `temp_ready=1` → published 20, 21, 23, 26.
- **Hysteresis (`TEMP_AVG_EN` off):** samples 29, 30, 29, 28, 31 → `over_temp` 0, 1, 1, 0, 1 after each publish.
- **Backpressure:**
  - `temp_ready=0` across two publishes, samples 22 then 27 → `temp_out` stays 22, `overrun` pulses once at the second publish edge.
  - Then `temp_ready=1` → transfer, `temp_valid` low next cycle.
- **Simultaneous transfer and publish:** `temp_ready=1` on the publish edge with `temp_valid=1` → `temp_valid` stays 1, `temp_out` takes the new value, no `overrun`.
- **Enable drop:**
  - Deassert `enable` on a capture edge with window 20/20/24/28 → IDLE, `temp_valid=0`, `temp_out` holds.
  - Re-enable with sample 40 → first publish is 40 (window preloaded).

Source files
------------

// File: rtl/temperature_sample_scheduler.sv
// -----------------------------------------------------------------------------
// temperature_sample_scheduler
//
// Sequences temperature acquisition for the on-board sensor path: waits out the
// sensor power-up / first-frame window, snapshots the decoded temperature byte
// once per sample period, optionally smooths it with a 4-sample moving average,
// publishes the result over a valid/ready handshake and keeps a hysteretic
// over-temperature alarm.
//
// Build option: define TEMP_AVG_EN to build the 4-entry averaging window.
// Without it the sample latched at the capture edge is published directly.
//
// Ports:
//   clk_200KHz     in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   enable         in   1  run request; low returns to IDLE
//   temperature_in in   8  decoded temperature, unsigned degC
//   temp_ready     in   1  consumer ready
//   temp_out       out  8  published temperature
//   temp_valid     out  1  temp_out holds an unconsumed sample
//   over_temp      out  1  hysteretic alarm on temp_out
//   overrun        out  1  one-cycle pulse when a publish is dropped
// -----------------------------------------------------------------------------
module temperature_sample_scheduler #(
    parameter int unsigned WARMUP        = 2560,
    parameter int unsigned SAMPLE_PERIOD = 2800,
    parameter logic [7:0]  HIGH_THRESH   = 8'd30,
    parameter logic [7:0]  LOW_THRESH    = 8'd28
) (
    input  logic       clk_200KHz,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] temperature_in,
    input  logic       temp_ready,
    output logic [7:0] temp_out,
    output logic       temp_valid,
    output logic       over_temp,
    output logic       overrun
);

    localparam int WW = $clog2(WARMUP + 1);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]    state_r;
    logic [WW-1:0] warm_cnt_r;
    logic [PW-1:0] period_cnt_r;
    logic          pub_pend_r;
    logic          drop_s;
    logic          capture_s;
    logic          publish_s;
    logic [7:0]    result_s;

    logic [7:0]    temp_out_r;
    logic          temp_valid_r;
    logic          over_temp_r;
    logic          overrun_r;

    // Alarm update: set at/above HIGH_THRESH, clear at/below LOW_THRESH, else hold.
    function automatic logic alarm_next(input logic cur, input logic [7:0] val);
        if (val >= HIGH_THRESH) begin
            return 1'b1;
        end else if (val <= LOW_THRESH) begin
            return 1'b0;
        end else begin
            return cur;
        end
    endfunction

    // Leaving WARMUP/RUN because enable fell; discards any capture/publish on this edge.
    assign drop_s    = (state_r != ST_IDLE) && !enable;
    assign capture_s = (state_r == ST_RUN) && enable && (period_cnt_r == PER_LAST);
    assign publish_s = pub_pend_r && enable;

    // Sequencer: IDLE -> WARMUP -> RUN with warm-up and sample-period counters.
    always_ff @(posedge clk_200KHz or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            warm_cnt_r   <= '0;
            period_cnt_r <= '0;
            pub_pend_r   <= 1'b0;
        end else begin
            // The publish edge is always the edge right after the capture edge.
            pub_pend_r <= capture_s;
            case (state_r)
                ST_IDLE: begin
                    warm_cnt_r   <= '0;
                    period_cnt_r <= '0;
                    if (enable) begin
                        state_r <= ST_WARMUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WARMUP: begin
                    if (!enable) begin
                        state_r    <= ST_IDLE;
                        warm_cnt_r <= '0;
                    end else if (warm_cnt_r == WARM_LAST) begin
                        state_r      <= ST_RUN;
                        warm_cnt_r   <= '0;
                        period_cnt_r <= '0;
                    end else begin
                        warm_cnt_r <= warm_cnt_r + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_r      <= ST_IDLE;
                        period_cnt_r <= '0;
                    end else if (period_cnt_r == PER_LAST) begin
                        period_cnt_r <= '0;
                    end else begin
                        period_cnt_r <= period_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    warm_cnt_r   <= '0;
                    period_cnt_r <= '0;
                end
            endcase
        end
    end

`ifdef TEMP_AVG_EN
    logic [7:0] win_r [4];
    logic       win_full_r;
    logic [1:0] wr_ptr_r;
    logic [9:0] sum_s;

    // Averaging window: first sample after an empty window preloads all entries,
    // later samples overwrite the oldest entry in ring order.
    always_ff @(posedge clk_200KHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                win_r[i] <= 8'd0;
            end
            win_full_r <= 1'b0;
            wr_ptr_r   <= 2'd0;
        end else if (drop_s) begin
            win_full_r <= 1'b0;
            wr_ptr_r   <= 2'd0;
        end else if (capture_s) begin
            if (!win_full_r) begin
                for (int i = 0; i < 4; i++) begin
                    win_r[i] <= temperature_in;
                end
                win_full_r <= 1'b1;
                wr_ptr_r   <= 2'd0;
            end else begin
                win_r[wr_ptr_r] <= temperature_in;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
        end else begin
            win_full_r <= win_full_r;
        end
    end

    assign sum_s    = {2'b00, win_r[0]} + {2'b00, win_r[1]}
                    + {2'b00, win_r[2]} + {2'b00, win_r[3]};
    // Divide by four with truncation.
    assign result_s = 8'(sum_s >> 2'd2);
`else
    logic [7:0] sample_r;

    // Sample latch: holds the byte taken at the capture edge for the publish edge.
    always_ff @(posedge clk_200KHz or negedge rst_n) begin
        if (!rst_n) begin
            sample_r <= 8'd0;
        end else if (capture_s) begin
            sample_r <= temperature_in;
        end else begin
            sample_r <= sample_r;
        end
    end

    assign result_s = sample_r;
`endif

    // Output stage: publish, handshake, overrun pulse and alarm, all registered.
    always_ff @(posedge clk_200KHz or negedge rst_n) begin
        if (!rst_n) begin
            temp_out_r   <= 8'd0;
            temp_valid_r <= 1'b0;
            over_temp_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (drop_s) begin
                temp_valid_r <= 1'b0;
            end else if (publish_s) begin
                // A transfer on the publish edge frees the slot for the new result.
                if (!temp_valid_r || temp_ready) begin
                    temp_out_r   <= result_s;
                    temp_valid_r <= 1'b1;
                    over_temp_r  <= alarm_next(over_temp_r, result_s);
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (temp_valid_r && temp_ready) begin
                temp_valid_r <= 1'b0;
            end else begin
                temp_valid_r <= temp_valid_r;
            end
        end
    end

    assign temp_out   = temp_out_r;
    assign temp_valid = temp_valid_r;
    assign over_temp  = over_temp_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_temperature_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_temperature_sample_scheduler
//
// Directed self-checking bench for temperature_sample_scheduler using short
// WARMUP / SAMPLE_PERIOD values. Expected values are hand-computed; where the
// TEMP_AVG_EN build changes the published value both answers are listed.
// -----------------------------------------------------------------------------
module tb_temperature_sample_scheduler;

    localparam int W  = 8;
    localparam int SP = 6;

`ifdef TEMP_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic       clk_200KHz = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] temperature_in;
    logic       temp_ready;
    logic [7:0] temp_out;
    logic       temp_valid;
    logic       over_temp;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int cyc;

    always #5 clk_200KHz = ~clk_200KHz;

    temperature_sample_scheduler #(
        .WARMUP        (W),
        .SAMPLE_PERIOD (SP)
    ) dut (
        .clk_200KHz     (clk_200KHz),
        .rst_n          (rst_n),
        .enable         (enable),
        .temperature_in (temperature_in),
        .temp_ready     (temp_ready),
        .temp_out       (temp_out),
        .temp_valid     (temp_valid),
        .over_temp      (over_temp),
        .overrun        (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_200KHz);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // From IDLE: raise enable and stop right after the first publish edge.
    task automatic start_run(input logic [7:0] t);
        enable         = 1'b1;
        temperature_in = t;
        ticks(W + SP + 2);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        temperature_in = 8'd0;
        temp_ready     = 1'b0;
        ticks(3);
        check("rst_temp_out",   temp_out,   0);
        check("rst_temp_valid", temp_valid, 0);
        check("rst_over_temp",  over_temp,  0);
        check("rst_overrun",    overrun,    0);
        rst_n = 1'b1;
        ticks(2);

        // First sample latency
        enable         = 1'b1;
        temperature_in = 8'd25;
        temp_ready     = 1'b1;
        cyc            = 0;
        do begin
            tick();
            cyc++;
        end while (!temp_valid && cyc < 100);
        check("first_latency", cyc - 1, W + SP + 1);
        check("first_out",     temp_out,   25);
        check("first_valid",   temp_valid, 1);
        check("first_alarm",   over_temp,  0);

        // Asynchronous reset in the middle of a run, no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        check("async_temp_out",   temp_out,   0);
        check("async_temp_valid", temp_valid, 0);
        check("async_over_temp",  over_temp,  0);
        check("async_overrun",    overrun,    0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef TEMP_AVG_EN
        // Moving average: 20,24,28,32 -> 20,21,23,26
        start_run(8'd20);
        check("avg0", temp_out, 20);
        temperature_in = 8'd24;
        ticks(SP);
        check("avg1", temp_out, 21);
        temperature_in = 8'd28;
        ticks(SP);
        check("avg2", temp_out, 23);
        temperature_in = 8'd32;
        ticks(SP);
        check("avg3",       temp_out,  26);
        check("avg3_valid", temp_valid, 1);
        check("avg3_alarm", over_temp,  0);
`else
        // Hysteresis: 29,30,29,28,31 -> alarm 0,1,1,0,1
        start_run(8'd29);
        check("hyst0_out", temp_out,  29);
        check("hyst0_alm", over_temp, 0);
        temperature_in = 8'd30;
        ticks(SP);
        check("hyst1_out", temp_out,  30);
        check("hyst1_alm", over_temp, 1);
        temperature_in = 8'd29;
        ticks(SP);
        check("hyst2_out", temp_out,  29);
        check("hyst2_alm", over_temp, 1);
        temperature_in = 8'd28;
        ticks(SP);
        check("hyst3_out", temp_out,  28);
        check("hyst3_alm", over_temp, 0);
        temperature_in = 8'd31;
        ticks(SP);
        check("hyst4_out", temp_out,  31);
        check("hyst4_alm", over_temp, 1);
`endif
        enable = 1'b0;
        ticks(2);
        check("stop_valid", temp_valid, 0);

        // Backpressure: 22 published, 27 dropped with one overrun pulse
        start_run(8'd22);
        check("bp_first_out",   temp_out,   22);
        check("bp_first_valid", temp_valid, 1);
        temp_ready     = 1'b0;
        temperature_in = 8'd27;
        ticks(SP - 1);
        check("bp_no_overrun_capture", overrun, 0);
        tick();
        check("bp_hold_out",   temp_out,   22);
        check("bp_hold_valid", temp_valid, 1);
        check("bp_overrun",    overrun,    1);
        tick();
        check("bp_overrun_one_cycle", overrun, 0);
        temp_ready = 1'b1;
        tick();
        check("bp_transfer_valid", temp_valid, 0);

        // Simultaneous transfer and publish
        temp_ready     = 1'b0;
        temperature_in = 8'd30;
        ticks(SP - 2);
        check("sim_v1_valid", temp_valid, 1);
        check("sim_v1_out",   temp_out,   AVG ? 25 : 30);
        check("sim_v1_alarm", over_temp,  AVG ? 0 : 1);
        temperature_in = 8'd34;
        ticks(SP - 1);
        check("sim_stable_out", temp_out, AVG ? 25 : 30);
        temp_ready = 1'b1;
        tick();
        check("sim_v2_valid",   temp_valid, 1);
        check("sim_v2_out",     temp_out,   AVG ? 28 : 34);
        check("sim_v2_overrun", overrun,    0);
        check("sim_v2_alarm",   over_temp,  AVG ? 0 : 1);
        tick();
        check("sim_after_valid", temp_valid, 0);
        enable = 1'b0;
        ticks(2);

        // Enable drop on a capture edge with window 20/20/24/28
        start_run(8'd20);
        check("drop_s0", temp_out, 20);
        temperature_in = 8'd24;
        ticks(SP);
        check("drop_s1", temp_out, AVG ? 21 : 24);
        temperature_in = 8'd28;
        ticks(SP);
        check("drop_s2", temp_out, AVG ? 23 : 28);
        temp_ready = 1'b0;
        ticks(SP - 2);
        check("drop_pre_valid", temp_valid, 1);
        enable         = 1'b0;
        temperature_in = 8'd32;
        tick();
        check("drop_valid", temp_valid, 0);
        check("drop_hold",  temp_out,   AVG ? 23 : 28);
        tick();
        check("drop_no_publish_valid", temp_valid, 0);
        check("drop_no_publish_out",   temp_out,   AVG ? 23 : 28);
        check("drop_no_overrun",       overrun,    0);

        // Re-enable: window empty again, first publish is the raw sample
        temp_ready = 1'b1;
        start_run(8'd40);
        check("reen_out",   temp_out,   40);
        check("reen_valid", temp_valid, 1);
        check("reen_alarm", over_temp,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
